// File: rtl/regfile_wb.sv
// regfile_wb: register file fed by the MEM/WB stage with write-through read ports,
// retire bookkeeping and a debug read port that does not bypass.
module regfile_wb #(
  parameter logic [15:0] RESET_VAL = 16'h0000,
  parameter int          RETIRE_W  = 32
) (
  input  logic                rfi_clk,
  input  logic                rfi_rst,
  input  logic [15:0]         rfi_instr,
  input  logic [15:0]         rfi_pc,
  input  logic [15:0]         rfi_result,
  input  logic [3:0]          rfi_wreg_addr,
  input  logic                rfi_reg_wrn,
  input  logic [3:0]          rfi_raddr1,
  input  logic [3:0]          rfi_raddr2,
  output logic [15:0]         rfo_rdata1,
  output logic [15:0]         rfo_rdata2,
  input  logic [3:0]          rfi_dbg_addr,
  output logic [15:0]         rfo_dbg_data,
  output logic [RETIRE_W-1:0] rfo_retired,
  output logic [15:0]         rfo_last_pc,
  output logic [15:0]         rfo_last_instr
);

  localparam logic [3:0] REG_INVALID = 4'hF;
  localparam int         NUM_REGS    = 15;

  logic [15:0]         regs_q [NUM_REGS];
  logic [15:0]         regs_d [NUM_REGS];
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [15:0]         last_pc_q, last_pc_d;
  logic [15:0]         last_instr_q, last_instr_d;
  logic                wr_en;
  logic                retire_en;

  // Address 4'hF has no storage, so a write to it is simply dropped.
  assign wr_en     = rfi_reg_wrn && (rfi_wreg_addr != REG_INVALID);
  assign retire_en = (rfi_instr != 16'h0000);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (rfi_wreg_addr == 4'(i))) begin
        regs_d[i] = rfi_result;
      end
    end
  end

  always_comb begin
    retired_d    = retired_q;
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;
    if (retire_en) begin
      retired_d    = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
      last_pc_d    = rfi_pc;
      last_instr_d = rfi_instr;
    end
  end

  // Address 4'hF matches no entry and reads as zero; the ID ports see the
  // value being written this cycle, the debug port only sees stored state.
  always_comb begin
    rfo_rdata1   = 16'h0000;
    rfo_rdata2   = 16'h0000;
    rfo_dbg_data = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rfi_raddr1 == 4'(i)) rfo_rdata1 = regs_q[i];
      if (rfi_raddr2 == 4'(i)) rfo_rdata2 = regs_q[i];
      if (rfi_dbg_addr == 4'(i)) rfo_dbg_data = regs_q[i];
    end
    if (wr_en && (rfi_raddr1 == rfi_wreg_addr)) rfo_rdata1 = rfi_result;
    if (wr_en && (rfi_raddr2 == rfi_wreg_addr)) rfo_rdata2 = rfi_result;
  end

  always_ff @(posedge rfi_clk or negedge rfi_rst) begin
    if (!rfi_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      retired_q    <= '0;
      last_pc_q    <= 16'h0000;
      last_instr_q <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      retired_q    <= retired_d;
      last_pc_q    <= last_pc_d;
      last_instr_q <= last_instr_d;
    end
  end

  assign rfo_retired    = retired_q;
  assign rfo_last_pc    = last_pc_q;
  assign rfo_last_instr = last_instr_q;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: scoreboard-driven bench for regfile_wb, with a second
// instance using a 4-bit retire counter to exercise wrap-around.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr, pc, result;
  logic [3:0]  waddr, raddr1, raddr2, dbg_addr;
  logic        wrn;

  logic [15:0] rdata1, rdata2, dbg_data, last_pc, last_instr;
  logic [31:0] retired;
  logic [15:0] w_rdata1, w_rdata2, w_dbg_data, w_last_pc, w_last_instr;
  logic [3:0]  w_retired;

  logic [15:0] mreg [15];
  logic [31:0] mret;
  logic [3:0]  mret4;
  logic [15:0] mlast_pc, mlast_instr;

  logic [31:0] sb_q [$];
  logic [31:0] exp;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  regfile_wb dut (
    .rfi_clk(clk), .rfi_rst(rst_n), .rfi_instr(instr), .rfi_pc(pc),
    .rfi_result(result), .rfi_wreg_addr(waddr), .rfi_reg_wrn(wrn),
    .rfi_raddr1(raddr1), .rfi_raddr2(raddr2), .rfo_rdata1(rdata1),
    .rfo_rdata2(rdata2), .rfi_dbg_addr(dbg_addr), .rfo_dbg_data(dbg_data),
    .rfo_retired(retired), .rfo_last_pc(last_pc), .rfo_last_instr(last_instr)
  );

  regfile_wb #(.RETIRE_W(4)) dut_w (
    .rfi_clk(clk), .rfi_rst(rst_n), .rfi_instr(instr), .rfi_pc(pc),
    .rfi_result(result), .rfi_wreg_addr(waddr), .rfi_reg_wrn(wrn),
    .rfi_raddr1(raddr1), .rfi_raddr2(raddr2), .rfo_rdata1(w_rdata1),
    .rfo_rdata2(w_rdata2), .rfi_dbg_addr(dbg_addr), .rfo_dbg_data(w_dbg_data),
    .rfo_retired(w_retired), .rfo_last_pc(w_last_pc), .rfo_last_instr(w_last_instr)
  );

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mreg[i] = 16'h0000;
    mret = 0; mret4 = 0; mlast_pc = 0; mlast_instr = 0;
  endtask

  // Advance one rising edge, update the reference model from the inputs
  // that were stable across that edge, then settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (wrn && waddr != 4'hF) mreg[waddr] = result;
      if (instr != 16'h0000) begin
        mret = mret + 1; mret4 = mret4 + 4'd1;
        mlast_pc = pc; mlast_instr = instr;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    instr = 0; pc = 0; result = 0; waddr = 4'hF; wrn = 0;
    raddr1 = 0; raddr2 = 0; dbg_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    raddr1 = 4'd3; raddr2 = 4'hF;
    sb_q.push_back(32'h0000); sb_q.push_back(32'h0000); sb_q.push_back(32'h0);
    #3;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata1 !== exp[15:0]) $display("[TB] FAIL reset_rdata1: got %h expected %h", rdata1, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata2 !== exp[15:0]) $display("[TB] FAIL reset_rdataF: got %h expected %h", rdata2, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (retired !== exp) $display("[TB] FAIL reset_retired: got %h expected %h", retired, exp); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    wrn = 1; waddr = 4'd3; result = 16'h1234; instr = 16'h4801; pc = 16'h0020;
    tick();
    idle_inputs(); raddr1 = 4'd3;
    sb_q.push_back({16'h0, mreg[3]}); sb_q.push_back(mret);
    #1;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata1 !== exp[15:0]) $display("[TB] FAIL pre_reset_r3: got %h expected %h", rdata1, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (retired !== exp) $display("[TB] FAIL pre_reset_retired: got %h expected %h", retired, exp); else pass_cnt++;

    #1; rst_n = 1'b0; model_reset();
    sb_q.push_back({16'h0, mreg[3]}); sb_q.push_back(mret); sb_q.push_back({16'h0, mlast_pc});
    #1;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata1 !== exp[15:0]) $display("[TB] FAIL async_reset_r3: got %h expected %h", rdata1, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (retired !== exp) $display("[TB] FAIL async_reset_retired: got %h expected %h", retired, exp); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (last_pc !== exp[15:0]) $display("[TB] FAIL async_reset_last_pc: got %h expected %h", last_pc, exp[15:0]); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    idle_inputs();
    wrn = 1; waddr = 4'd5; result = 16'hBEEF; raddr1 = 4'd5; dbg_addr = 4'd5;
    sb_q.push_back(32'hBEEF); sb_q.push_back({16'h0, mreg[5]});
    #1;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata1 !== exp[15:0]) $display("[TB] FAIL wr_bypass: got %h expected %h", rdata1, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (dbg_data !== exp[15:0]) $display("[TB] FAIL dbg_no_bypass: got %h expected %h", dbg_data, exp[15:0]); else pass_cnt++;
    tick();
    wrn = 0;
    sb_q.push_back(32'hBEEF); sb_q.push_back(32'hBEEF);
    #1;
    exp = sb_q.pop_front(); total_cnt++;
    if (dbg_data !== exp[15:0]) $display("[TB] FAIL dbg_after_edge: got %h expected %h", dbg_data, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata1 !== exp[15:0]) $display("[TB] FAIL rd_after_edge: got %h expected %h", rdata1, exp[15:0]); else pass_cnt++;
  endtask

  task automatic test_invalid_writes();
    idle_inputs();
    wrn = 1; waddr = 4'hF; result = 16'hAAAA; raddr1 = 4'hF; raddr2 = 4'hF; dbg_addr = 4'hF;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    #1;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata1 !== exp[15:0]) $display("[TB] FAIL invalid_rd1: got %h expected %h", rdata1, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata2 !== exp[15:0]) $display("[TB] FAIL invalid_rd2: got %h expected %h", rdata2, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (dbg_data !== exp[15:0]) $display("[TB] FAIL invalid_dbg: got %h expected %h", dbg_data, exp[15:0]); else pass_cnt++;
    tick();
    wrn = 0;
    for (int i = 0; i < 15; i++) begin
      dbg_addr = 4'(i);
      sb_q.push_back({16'h0, mreg[i]});
      #1;
      exp = sb_q.pop_front(); total_cnt++;
      if (dbg_data !== exp[15:0]) $display("[TB] FAIL invalid_r%0d: got %h expected %h", i, dbg_data, exp[15:0]); else pass_cnt++;
    end
    wrn = 0; waddr = 4'd2; result = 16'h5555; raddr1 = 4'd2; dbg_addr = 4'd2;
    sb_q.push_back({16'h0, mreg[2]});
    #1;
    exp = sb_q.pop_front(); total_cnt++;
    if (rdata1 !== exp[15:0]) $display("[TB] FAIL disabled_bypass: got %h expected %h", rdata1, exp[15:0]); else pass_cnt++;
    tick();
    sb_q.push_back(32'h0000);
    exp = sb_q.pop_front(); total_cnt++;
    if (dbg_data !== exp[15:0]) $display("[TB] FAIL disabled_r2: got %h expected %h", dbg_data, exp[15:0]); else pass_cnt++;
  endtask

  task automatic test_dual_bypass();
    idle_inputs();
    wrn = 1; waddr = 4'd7; result = 16'h00C3; raddr1 = 4'd7; raddr2 = 4'd7;
    for (int step = 0; step < 2; step++) begin
      sb_q.push_back(32'h00C3); sb_q.push_back(32'h00C3);
      #1;
      exp = sb_q.pop_front(); total_cnt++;
      if (rdata1 !== exp[15:0]) $display("[TB] FAIL dual_rd1_step%0d: got %h expected %h", step, rdata1, exp[15:0]); else pass_cnt++;
      exp = sb_q.pop_front(); total_cnt++;
      if (rdata2 !== exp[15:0]) $display("[TB] FAIL dual_rd2_step%0d: got %h expected %h", step, rdata2, exp[15:0]); else pass_cnt++;
      tick();
      wrn = 0; result = 16'hFFFF;
    end
  endtask

  task automatic test_retire();
    logic [15:0] seq_instr [6];
    logic [15:0] seq_pc [6];
    logic        seq_wrn [6];
    seq_instr = '{16'h4801, 16'h0000, 16'h6A05, 16'h6A05, 16'h6A05, 16'h0000};
    seq_pc    = '{16'h0010, 16'h9999, 16'h0011, 16'h0011, 16'h0011, 16'h7777};
    seq_wrn   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    idle_inputs();
    for (int s = 0; s < 6; s++) begin
      instr = seq_instr[s]; pc = seq_pc[s]; wrn = seq_wrn[s];
      waddr = 4'd1; result = 16'h1111; dbg_addr = 4'd1;
      tick();
      sb_q.push_back(mret); sb_q.push_back({16'h0, mlast_pc}); sb_q.push_back({16'h0, mlast_instr});
      exp = sb_q.pop_front(); total_cnt++;
      if (retired !== exp) $display("[TB] FAIL retire_count_s%0d: got %h expected %h", s, retired, exp); else pass_cnt++;
      exp = sb_q.pop_front(); total_cnt++;
      if (last_pc !== exp[15:0]) $display("[TB] FAIL retire_pc_s%0d: got %h expected %h", s, last_pc, exp[15:0]); else pass_cnt++;
      exp = sb_q.pop_front(); total_cnt++;
      if (last_instr !== exp[15:0]) $display("[TB] FAIL retire_instr_s%0d: got %h expected %h", s, last_instr, exp[15:0]); else pass_cnt++;
    end
    wrn = 0;
    sb_q.push_back(32'h1111);
    #1;
    exp = sb_q.pop_front(); total_cnt++;
    if (dbg_data !== exp[15:0]) $display("[TB] FAIL bubble_write_r1: got %h expected %h", dbg_data, exp[15:0]); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    idle_inputs();
    dbg_addr = 4'd7;
    for (int s = 0; s < 16; s++) begin
      instr = 16'h2000 + 16'(s); pc = 16'h0100 + 16'(s);
      tick();
      sb_q.push_back({28'h0, mret4}); sb_q.push_back(mret);
      exp = sb_q.pop_front(); total_cnt++;
      if (w_retired !== exp[3:0]) $display("[TB] FAIL wrap_count_s%0d: got %h expected %h", s, w_retired, exp[3:0]); else pass_cnt++;
      exp = sb_q.pop_front(); total_cnt++;
      if (retired !== exp) $display("[TB] FAIL wide_count_s%0d: got %h expected %h", s, retired, exp); else pass_cnt++;
    end
    instr = 0;
    sb_q.push_back({16'h0, mlast_pc}); sb_q.push_back({16'h0, mreg[7]});
    #1;
    exp = sb_q.pop_front(); total_cnt++;
    if (w_last_pc !== exp[15:0]) $display("[TB] FAIL wrap_last_pc: got %h expected %h", w_last_pc, exp[15:0]); else pass_cnt++;
    exp = sb_q.pop_front(); total_cnt++;
    if (w_dbg_data !== exp[15:0]) $display("[TB] FAIL wrap_no_side_effect: got %h expected %h", w_dbg_data, exp[15:0]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_invalid_writes();
    test_dual_bypass();
    test_retire();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Consumer end of the MEM/WB interface: register file whose single write port is driven directly by the MEM/WB stage outputs (instr, pc, result, wreg_addr, reg_wrn).
- Provides two combinational read ports to the ID stage, with same-cycle write-through bypass.
- Provides retire bookkeeping (retired-instruction counter, last retired pc/instr) and a debug read port for the board display.

Parameters:
- RESET_VAL, 16'h0000, value loaded into every architectural register on reset.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- rfi_clk  input  1  clock; all state updates on rising edge.
- rfi_rst  input  1  asynchronous, active-low reset.
- rfi_instr  input  16  instruction word from MEM/WB; 16'h0000 marks a bubble.
- rfi_pc  input  16  pc of that instruction.
- rfi_result  input  16  write-back data.
- rfi_wreg_addr  input  4  destination register; `REG_INVALID (4'hF) means none.
- rfi_reg_wrn  input  1  write request, 1 = write.
- rfi_raddr1  input  4  read address, port 1.
- rfi_raddr2  input  4  read address, port 2.
- rfo_rdata1  output  16  read data, port 1.
- rfo_rdata2  output  16  read data, port 2.
- rfi_dbg_addr  input  4  debug read address.
- rfo_dbg_data  output  16  debug read data, no bypass.
- rfo_retired  output  RETIRE_W  count of retired non-bubble instructions.
- rfo_last_pc  output  16  pc of the most recently retired instruction.
- rfo_last_instr  output  16  the most recently retired instruction word.

Behaviour:
- Storage: 15 registers, addresses 0..14.
  - Address 4'hF (`REG_INVALID) is not storage.
  - Reads of 4'hF return 16'h0000 on all read ports.
- Reset (rfi_rst=0, asynchronous, takes effect immediately, including mid-operation):
  - All registers = RESET_VAL.
  - rfo_retired = 0, rfo_last_pc = 0, rfo_last_instr = 0.
  - Read outputs therefore show RESET_VAL, or 0 for address 4'hF.
  - Power-up (initial) values match the reset values.
- Write:
  - At a rising edge with rfi_rst=1, rfi_reg_wrn=1 and rfi_wreg_addr != 4'hF, reg[rfi_wreg_addr] <= rfi_result.
  - If rfi_reg_wrn=1 with address 4'hF, the write is silently discarded.
  - If rfi_reg_wrn=0, no write, regardless of the address.
- Read ports 1/2 are combinational, zero latency.
  - Bypass: if raddrN == rfi_wreg_addr, rfi_reg_wrn=1 and the address != 4'hF, rdataN = rfi_result (the value being written this cycle).
  - Otherwise rdataN = reg[raddrN].
  - Both ports may bypass simultaneously.
- Debug port: combinational, rfo_dbg_data = reg[rfi_dbg_addr], with no bypass. It shows the value written only from the cycle after the write.
- Retire, at a rising edge with rfi_rst=1 and rfi_instr != 16'h0000:
  - rfo_retired <= rfo_retired + 1, modulo 2^RETIRE_W; it wraps from all-ones to 0 without a flag.
  - rfo_last_pc <= rfi_pc; rfo_last_instr <= rfi_instr.
- Bubble: rfi_instr == 0 (MEM/WB flushed or in reset) leaves all retire outputs unchanged.
  - A write with a bubble instr is still performed if rfi_reg_wrn=1; retire and write are independent.
- Held input: if MEM/WB holds (keep), the same instr is presented again. It is counted again every cycle it is presented; MEM/WB is responsible for bubbling instead of repeating.
- No internal state machine beyond these registers; no stall outputs.

Test Plan:
- Reset: pulse rfi_rst low mid-cycle after writing 16'h1234 to r3 -> immediately rdata1(raddr1=3)=0000, rfo_retired=0, rfo_last_pc=0.
- Write then read: wrn=1, waddr=5, result=16'hBEEF, raddr1=5 -> rdata1=BEEF in the same cycle (bypass); rfo_dbg_data(5)=old value, becomes BEEF after the edge.
- Invalid/disabled writes:
  - wrn=1, waddr=4'hF, result=16'hAAAA -> no register changes; rdata with raddr=F reads 0000.
  - wrn=0, waddr=2, result=16'h5555 -> r2 unchanged.
- Dual bypass: raddr1=raddr2=waddr=7, wrn=1, result=16'h00C3 -> both rdata=00C3; after the edge, with wrn=0, both still 00C3.
- Retire: present instr 0x4801/pc 0x0010, then a bubble (instr=0), then 0x6A05/pc 0x0011 -> rfo_retired 1,1,2; last_pc 0010,0010,0011; last_instr follows.
- Counter wrap: RETIRE_W=4, retire 16 instructions -> rfo_retired returns to 0 with no other side effect.
